// File: rtl/algo_1r2w_refr_sched_pkg.sv
// Shared types and sizing for the 1R2W refresh scheduler.
package algo_1r2w_refr_sched_pkg;

  localparam int unsigned NUMPBNK = 4;
  localparam int unsigned NUMRBNK = 2;
  localparam int unsigned BITRBNK = 1;
  localparam int unsigned MAXPEND = 4;
  localparam int unsigned BITPEND = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } refrState_t;

  // Mask with the low nBnk bits set; a round is complete when done|issue equals it.
  function automatic logic [NUMPBNK-1:0] roundMask(input int unsigned nBnk);
    logic [NUMPBNK-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUMPBNK; i++) begin
      if (i < nBnk) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/algo_1r2w_refr_sched_pend_cnt.sv
// Saturating pending-tick counter with sticky overflow flag.
module algo_refr_pend_cnt
  import algo_1r2w_refr_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               roundDone,
  output logic [BITPEND-1:0] pend,
  output logic [BITPEND-1:0] pendNext_c,
  output logic               urgent,
  output logic               ovfl
);

  logic atMax;
  logic accept;
  logic drop;

  // A completing round frees a slot, so a tick at the limit is only dropped without one.
  always_comb begin
    atMax      = (pend == BITPEND'(MAXPEND));
    drop       = tick && atMax && !roundDone;
    accept     = tick && !drop;
    pendNext_c = pend + BITPEND'(accept) - BITPEND'(roundDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend   <= '0;
      urgent <= 1'b0;
      ovfl   <= 1'b0;
    end else begin
      pend   <= pendNext_c;
      urgent <= (pendNext_c == BITPEND'(MAXPEND));
      ovfl   <= ovfl | drop;
    end
  end

endmodule

// File: rtl/algo_1r2w_refr_sched.sv
// Refresh scheduler: turns refresh ticks into per-bank refresh commands, round-robin over sub-banks.
module algo_1r2w_refr_sched
  import algo_1r2w_refr_sched_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       refr,
  input  logic [NUMPBNK-1:0]         acc_vld,
  input  logic [NUMPBNK*BITRBNK-1:0] acc_rbnk,
  output logic [NUMPBNK-1:0]         t_refrB,
  output logic [NUMPBNK*BITRBNK-1:0] t_bankB,
  output logic                       ref_urgent,
  output logic                       ref_ovfl,
  output logic [BITPEND-1:0]         ref_pend
);

  refrState_t         state, stateNext;
  logic [BITRBNK-1:0] curRbnk, curRbnkNext;
  logic [NUMPBNK-1:0] done, doneNext, issue;
  logic               roundDone;
  logic [BITPEND-1:0] pendNext;

  algo_refr_pend_cnt uPendCnt (
    .clk        (clk),
    .rst        (rst),
    .tick       (refr),
    .roundDone  (roundDone),
    .pend       (ref_pend),
    .pendNext_c (pendNext),
    .urgent     (ref_urgent),
    .ovfl       (ref_ovfl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      curRbnk <= '0;
      done    <= '0;
    end else begin
      state   <= stateNext;
      curRbnk <= curRbnkNext;
      done    <= doneNext;
    end
  end

  // Active whenever any refresh is still owed.
  always_comb begin
    stateNext = state;
    if (pendNext != '0) stateNext = ACTIVE;
    else                stateNext = IDLE;
  end

  // Per-bank issue: a bank is skipped only while its own access hits the sub-bank in refresh.
  always_comb begin
    issue       = '0;
    roundDone   = 1'b0;
    doneNext    = done;
    curRbnkNext = curRbnk;
    t_refrB     = '0;
    t_bankB     = '0;
    case (state)
      ACTIVE: begin
        for (int unsigned p = 0; p < NUMPBNK; p++) begin
          issue[p] = !done[p] &&
                     !(acc_vld[p] && (acc_rbnk[p*BITRBNK +: BITRBNK] == curRbnk));
        end
        roundDone = ((done | issue) == roundMask(NUMPBNK));
        if (roundDone) begin
          doneNext    = '0;
          curRbnkNext = (curRbnk == BITRBNK'(NUMRBNK - 1)) ? '0 : curRbnk + BITRBNK'(1);
        end else begin
          doneNext = done | issue;
        end
      end
      default: doneNext = '0;
    endcase
    t_refrB = issue;
    for (int unsigned p = 0; p < NUMPBNK; p++) begin
      t_bankB[p*BITRBNK +: BITRBNK] = issue[p] ? curRbnk : '0;
    end
  end

endmodule

// File: doc/algo_1r2w_refr_sched.md
Name: algo_1r2w_refr_sched

Overview:
Refresh scheduler for the DRAM-backed 1R2W algorithm memory. It turns the top-level refresh tick into per-physical-bank refresh commands (refrB/bankB). Refresh sub-banks are visited round-robin. A physical bank is skipped in any cycle where its read/write access hits the sub-bank being refreshed, and that bank is retried later. It sits beside the algorithm core and drives the refresh port of every T1/T2 instance.

Parameters:
NUMPBNK, 4, physical DRAM banks driven (T1 instances + T2 instances)
NUMRBNK, 2, refresh sub-banks per physical bank
BITRBNK, 1, width of sub-bank index
MAXPEND, 4, pending-tick saturation limit
BITPEND, 3, pending counter width (holds 0..MAXPEND)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
refr  in  1  refresh tick, one-cycle pulse
acc_vld  in  NUMPBNK  bank p has a read/write access this cycle
acc_rbnk  in  NUMPBNK*BITRBNK  refresh sub-bank touched by bank p's access
t_refrB  out  NUMPBNK  refresh command to bank p
t_bankB  out  NUMPBNK*BITRBNK  sub-bank refreshed by bank p
ref_urgent  out  1  pending == MAXPEND; upstream stalls accesses
ref_ovfl  out  1  sticky; a tick arrived while pending == MAXPEND
ref_pend  out  BITPEND  current pending count

Behaviour:
- Reset (async, active-high) values: pending=0, cur_rbnk=0, done mask=0, ref_ovfl=0. All outputs read 0 during and immediately after reset.
- States:
  - IDLE (pending==0)
  - ACTIVE (pending>0): refreshing cur_rbnk across all banks
- Per cycle in ACTIVE, for each bank p with done[p]==0:
  - conflict[p] = acc_vld[p] && acc_rbnk[p]==cur_rbnk.
  - If there is no conflict, t_refrB[p]=1 and t_bankB[p]=cur_rbnk in the same cycle (combinational from registered state plus acc inputs; zero latency). done[p] is set at the clock edge.
  - With a conflict, t_refrB[p]=0 and the bank is retried next cycle.
- t_bankB[p] = cur_rbnk whenever t_refrB[p]=1, and 0 otherwise.
- Round completion: when (done | issued_this_cycle) is all ones:
  - done clears;
  - cur_rbnk increments, wrapping NUMRBNK-1 -> 0;
  - pending decrements, merged with any tick in the same cycle.
- Pending arithmetic, per cycle: pending_next = pending + tick_accept - round_complete.
  - tick_accept = refr && !(pending==MAXPEND && !round_complete).
  - If refr arrives while pending==MAXPEND and no round completes: the tick is dropped and ref_ovfl is set (sticky until reset).
  - A simultaneous tick and completion leaves pending unchanged. This is legal even at MAXPEND.
- IDLE: all t_refrB=0, done stays 0, cur_rbnk holds. A tick moves the block to ACTIVE next cycle; no issue in the tick cycle itself.
- ref_urgent = (pending==MAXPEND), driven from the register. Upstream must deassert acc_vld on conflicting banks while it is high. If conflicts persist anyway, the block keeps retrying; it never forces a refresh.
- Conflict checking is per bank only. Banks are independent, so one bank may finish a round several cycles before another.
- Reset mid-round: the partial done mask and the pending count are discarded.

Decomposition:
- Shared package: refresh state enum (IDLE, ACTIVE), and a function computing the round_complete predicate width from NUMPBNK.
- One natural sub-module: algo_refr_pend_cnt, the saturating up/down pending counter with overflow flag. The round-robin and conflict logic stays in the top module.

Test Plan:
1. Reset with NUMPBNK=4, NUMRBNK=2, single refr pulse, acc_vld=0.
   -> Next cycle t_refrB=4'b1111, t_bankB all 0. Following cycle pending=0, cur_rbnk=1, t_refrB=0.
2. Tick with acc_vld=4'b0010, acc_rbnk[1]=0 held for 3 cycles.
   -> Banks 0, 2, 3 refresh in the first ACTIVE cycle. Bank 1 refreshes the cycle after acc_vld[1] drops. Round completes only then.
3. Five ticks back-to-back with all banks conflicting.
   -> pending reaches 4 and ref_urgent=1. The fifth tick sets ref_ovfl=1 while pending stays 4.
4. refr in the same cycle a round completes with pending=4.
   -> pending stays 4, ref_ovfl stays 0, cur_rbnk advances.
5. Three completed rounds with NUMRBNK=2.
   -> t_bankB sequence 0, 1, 0 (wrap-around).
6. Async rst asserted mid-round with done=4'b0101.
   -> Outputs 0 immediately. After release, the next tick refreshes all 4 banks at sub-bank 0.
